// File: rtl/alu_pkg.sv
// Shared types and opcode constants for the alu issue stage and its command FIFO.
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    // One queued operand command as presented to the alu.
    typedef struct packed {
        logic [1:0]           op;
        logic [ALU_WIDTH-1:0] a;
        logic [ALU_WIDTH-1:0] b;
    } alu_cmd_t;

    // One captured alu result with its status bits.
    typedef struct packed {
        logic [2*ALU_WIDTH-1:0] data;
        logic                   ovf;
        logic                   cout;
    } alu_res_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// DEPTH-entry command FIFO. Pointers carry one extra wrap bit so that
// full and empty are distinguishable without a separate occupancy counter.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push_i,
    input  logic     pop_i,
    input  alu_cmd_t wdata_i,
    output logic     full_o,
    output logic     empty_o,
    output alu_cmd_t head_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_INC = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    alu_cmd_t    mem_q [DEPTH];
    logic        do_push_s;
    logic        do_pop_s;

    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;
    assign head_o    = mem_q[rd_ptr_q[AW-1:0]];

    // Advance write/read pointers on accepted push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_INC;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_INC;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; cleared on reset so no stale command survives it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/retire stage around an external combinational alu: queues commands,
// drives the FIFO head into the alu and registers its result behind a
// valid/ready handshake. Also tracks a sticky overflow flag and a retire count.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [WIDTH-1:0]   cmd_a,
    input  logic [WIDTH-1:0]   cmd_b,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [1:0]         alu_op_code,
    input  logic [2*WIDTH-1:0] alu_out,
    input  logic               alu_overflow,
    input  logic               alu_c_out,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*WIDTH-1:0] res_data,
    output logic               res_ovf,
    output logic               res_cout,
    output logic               sticky_ovf,
    output logic [CNT_W-1:0]   done_cnt,
    output logic               busy
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    alu_cmd_t          cmd_in_s;
    alu_cmd_t          head_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              push_s;
    logic              capture_s;
    logic              handshake_s;

    alu_res_t          res_q, res_d;
    logic              res_valid_q, res_valid_d;
    logic              sticky_q, sticky_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // cmd_ready is held low during reset and never depends on a same-cycle pop.
    assign cmd_ready   = rst_n && !fifo_full_s;
    assign push_s      = cmd_valid && cmd_ready;
    assign capture_s   = !fifo_empty_s && (!res_valid_q || res_ready);
    assign handshake_s = res_valid_q && res_ready;

    // Pack incoming command fields into the FIFO entry type.
    always_comb begin
        cmd_in_s    = '0;
        cmd_in_s.op = cmd_op;
        cmd_in_s.a  = cmd_a;
        cmd_in_s.b  = cmd_b;
    end

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .pop_i   (capture_s),
        .wdata_i (cmd_in_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .head_o  (head_s)
    );

    // Present the FIFO head to the alu, or zeros when nothing is queued.
    always_comb begin
        alu_a       = '0;
        alu_b       = '0;
        alu_op_code = 2'b00;
        if (!fifo_empty_s) begin
            alu_a       = head_s.a;
            alu_b       = head_s.b;
            alu_op_code = head_s.op;
        end else begin
            alu_a       = '0;
            alu_b       = '0;
            alu_op_code = 2'b00;
        end
    end

    // Next-state for result register, sticky flag and retire counter.
    always_comb begin
        res_d       = res_q;
        res_valid_d = res_valid_q;
        sticky_d    = sticky_q;
        cnt_d       = cnt_q;

        if (capture_s) begin
            res_d.data  = alu_out;
            res_d.ovf   = alu_overflow;
            res_d.cout  = alu_c_out;
            res_valid_d = 1'b1;
        end else if (handshake_s) begin
            res_valid_d = 1'b0;
        end else begin
            res_valid_d = res_valid_q;
        end

        // A new overflow outranks a simultaneous clear.
        if (capture_s && alu_overflow) begin
            sticky_d = 1'b1;
        end else if (clear) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end

        // Clear restarts the count, still counting a handshake in that cycle.
        if (clear) begin
            cnt_d = handshake_s ? CNT_ONE : '0;
        end else if (handshake_s) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Result, flag and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q       <= '0;
            res_valid_q <= 1'b0;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
        end
    end

    assign res_valid  = res_valid_q;
    assign res_data   = res_q.data;
    assign res_ovf    = res_q.ovf;
    assign res_cout   = res_q.cout;
    assign sticky_ovf = sticky_q;
    assign done_cnt   = cnt_q;
    assign busy       = !fifo_empty_s || res_valid_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage paired with a stub alu. Expected results are
// queued when a command is accepted and compared when the result retires.
module tb_alu_issue_stage;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [1:0]  alu_op_code;
    logic [15:0] alu_out;
    logic        alu_overflow;
    logic        alu_c_out;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_ovf;
    logic        res_cout;
    logic        sticky_ovf;
    logic [3:0]  done_cnt;
    logic        busy;

    int          checks;
    int          errors;
    int          last_wait;
    logic [3:0]  exp_cnt;
    alu_res_t    sb[$];

    alu_issue_stage #(
        .WIDTH (8),
        .DEPTH (2),
        .CNT_W (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op_code  (alu_op_code),
        .alu_out      (alu_out),
        .alu_overflow (alu_overflow),
        .alu_c_out    (alu_c_out),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_ovf      (res_ovf),
        .res_cout     (res_cout),
        .sticky_ovf   (sticky_ovf),
        .done_cnt     (done_cnt),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stub alu: a == 8'hFF flags overflow; c_out is the 8-bit add carry.
    always_comb begin
        logic [8:0] sum9;
        sum9 = {1'b0, alu_a} + {1'b0, alu_b};
        case (alu_op_code)
            OP_ADD:  alu_out = {8'h00, alu_a} + {8'h00, alu_b};
            OP_SUB:  alu_out = {8'h00, alu_a} - {8'h00, alu_b};
            OP_MUL:  alu_out = alu_a * alu_b;
            default: alu_out = {8'h00, alu_a & alu_b};
        endcase
        alu_overflow = (alu_a == 8'hFF);
        alu_c_out    = (alu_op_code == OP_ADD) ? sum9[8] : 1'b0;
    end

    function automatic alu_res_t model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        alu_res_t r;
        int unsigned ua, ub;
        ua = a;
        ub = b;
        case (op)
            2'b00:   r.data = 16'((ua + ub) & 32'hFFFF);
            2'b01:   r.data = 16'((ua + 32'h10000 - ub) & 32'hFFFF);
            2'b10:   r.data = 16'(ua * ub);
            default: r.data = {8'h00, a & b};
        endcase
        r.ovf  = (a == 8'hFF);
        r.cout = (op == 2'b00) && ((ua + ub) > 32'd255);
        return r;
    endfunction

    // Scoreboard monitor: retire-count tracking and in-order result checks.
    always @(negedge clk) begin
        logic     hs;
        alu_res_t e;
        if (rst_n) begin
            checks++;
            if (done_cnt !== exp_cnt) begin
                errors++;
                $display("FAIL done_cnt: got %0d expected %0d at %0t", done_cnt, exp_cnt, $time);
            end
            hs = res_valid && res_ready;
            if (hs) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got %h with empty scoreboard", res_data);
                end else begin
                    e = sb.pop_front();
                    if ({res_data, res_ovf, res_cout} !== {e.data, e.ovf, e.cout}) begin
                        errors++;
                        $display("FAIL result: got %h/%b/%b expected %h/%b/%b",
                                 res_data, res_ovf, res_cout, e.data, e.ovf, e.cout);
                    end
                end
            end
            if (clear) exp_cnt = hs ? 4'd1 : 4'd0;
            else if (hs) exp_cnt = exp_cnt + 4'd1;
        end
    end

    task automatic push_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int waited;
        waited    = 0;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            waited++;
            if (waited > 50) begin
                checks++;
                errors++;
                $display("FAIL push_timeout: cmd_ready stayed %b, expected 1", cmd_ready);
                cmd_valid = 1'b0;
                last_wait = waited;
                return;
            end
        end
        sb.push_back(model(op, a, b));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        last_wait = waited;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", sb.size());
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({cmd_ready, res_valid, res_data, sticky_ovf, done_cnt, busy, alu_a, alu_b, alu_op_code} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b val=%b data=%h busy=%b, expected all 0",
                     cmd_ready, res_valid, res_data, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b busy=%b expected 1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_single();
        res_ready = 1'b1;
        push_cmd(OP_ADD, 8'd45, 8'd61);
        @(posedge clk);
        #1;
        checks++;
        if (res_valid !== 1'b1 || res_data !== 16'h006A) begin
            errors++;
            $display("FAIL single_latency: got val=%b data=%h expected 1/006a", res_valid, res_data);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done_cnt !== 4'd1) begin
            errors++;
            $display("FAIL single_count: got %0d expected 1", done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] ops [4];
        ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_MUL; ops[3] = OP_AND;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_cmd(ops[i], 8'd45, 8'd61);
            checks++;
            if (last_wait != 0) begin
                errors++;
                $display("FAIL b2b_ready: push %0d waited %0d cycles, expected 0", i, last_wait);
            end
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_throughput: got pending=%0d busy=%b expected 0/0", sb.size(), busy);
        end
    endtask

    task automatic test_backpressure();
        pulse_clear();
        res_ready = 1'b0;
        push_cmd(OP_ADD, 8'd1, 8'd2);
        push_cmd(OP_SUB, 8'd10, 8'd3);
        push_cmd(OP_MUL, 8'd7, 8'd6);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cmd_ready !== 1'b0 || res_valid !== 1'b1 || res_data !== 16'h0003) begin
                errors++;
                $display("FAIL bp_hold: got rdy=%b val=%b data=%h expected 0/1/0003",
                         cmd_ready, res_valid, res_data);
            end
            @(posedge clk);
            #1;
        end
        res_ready = 1'b1;
        wait_drain();
        @(posedge clk);
        #1;
        checks++;
        if (done_cnt !== 4'd3) begin
            errors++;
            $display("FAIL bp_count: got %0d expected 3", done_cnt);
        end
    endtask

    task automatic test_overflow();
        res_ready = 1'b1;
        push_cmd(OP_ADD, 8'hFF, 8'h01);
        @(posedge clk);
        #1;
        checks++;
        if (sticky_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: got %b expected 1", sticky_ovf);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sticky_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b expected 1", sticky_ovf);
        end
        push_cmd(OP_SUB, 8'hFF, 8'h00);
        pulse_clear();
        checks++;
        if (sticky_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_wins: got %b expected 1", sticky_ovf);
        end
        repeat (2) @(posedge clk);
        #1;
        pulse_clear();
        checks++;
        if (sticky_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b expected 0", sticky_ovf);
        end
    endtask

    task automatic test_wrap();
        res_ready = 1'b1;
        pulse_clear();
        for (int i = 0; i < 17; i++) begin
            push_cmd(2'(i), 8'(i * 3), 8'(i + 5));
        end
        wait_drain();
        @(posedge clk);
        #1;
        checks++;
        if (done_cnt !== 4'd1) begin
            errors++;
            $display("FAIL wrap_count: got %0d expected 1", done_cnt);
        end
        res_ready = 1'b0;
        push_cmd(OP_AND, 8'hF0, 8'h3C);
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        pulse_clear();
        checks++;
        if (done_cnt !== 4'd1) begin
            errors++;
            $display("FAIL clear_handshake: got %0d expected 1", done_cnt);
        end
    endtask

    task automatic test_mid_reset();
        res_ready = 1'b0;
        push_cmd(OP_ADD, 8'hFF, 8'd9);
        push_cmd(OP_SUB, 8'd5, 8'd6);
        push_cmd(OP_MUL, 8'd3, 8'd3);
        checks++;
        if (res_valid !== 1'b1 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_setup: got val=%b rdy=%b expected 1/0", res_valid, cmd_ready);
        end
        #2;
        rst_n = 1'b0;
        sb.delete();
        exp_cnt = 4'd0;
        #1;
        checks++;
        if ({cmd_ready, res_valid, res_data, res_ovf, res_cout, sticky_ovf, done_cnt, busy,
             alu_a, alu_b, alu_op_code} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: got rdy=%b val=%b data=%h sticky=%b busy=%b a=%h expected all 0",
                     cmd_ready, res_valid, res_data, sticky_ovf, busy, alu_a);
        end
        res_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_release: got busy=%b rdy=%b val=%b expected 0/1/0",
                     busy, cmd_ready, res_valid);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        last_wait = 0;
        exp_cnt   = 4'd0;
        clear     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_a     = 8'h00;
        cmd_b     = 8'h00;
        res_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_wrap();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
